// File: rtl/apb_timer_mch_if.sv
// APB bus bundle for the multi-channel timer.
// Handshake signals only; clock, reset, debug and interrupt stay plain ports.
interface apb_timer_mch_if #(
  parameter int ADDR_W = 12
);
  logic              tim_psel;
  logic              tim_penable;
  logic              tim_pwrite;
  logic [ADDR_W-1:0] tim_paddr;
  logic [31:0]       tim_pwdata;
  logic [3:0]        tim_pstrb;
  logic [31:0]       tim_prdata;
  logic              tim_pready;
  logic              tim_pslverr;

  modport master (
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_prdata, tim_pready, tim_pslverr
  );

  modport slave (
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_prdata, tim_pready, tim_pslverr
  );
endinterface

// File: rtl/apb_timer_mch.sv
// APB-slave general-purpose timer: CNT_W-bit up-counter with power-of-two prescaler,
// debug halt and NUM_CH compare channels with optional clear-on-match.
module apb_timer_mch #(
  parameter int CNT_W  = 64,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 12
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  apb_timer_mch_if.slave apb,
  input  logic           dbg_mode,
  output logic           tim_int
);

  typedef enum logic [3:0] {
    REG_TCR, REG_TDR0, REG_TDR1, REG_TIER, REG_TISR, REG_TCMR, REG_THCSR,
    REG_CMP_L, REG_CMP_H, REG_NONE
  } reg_e;

  localparam logic [ADDR_W-7:0] CH_PAGE = 4;  // 0x100 >> 6

  function automatic logic [31:0] lane_merge(input logic [31:0] cur, input logic [31:0] wd,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[b*8 +: 8] = strb[b] ? wd[b*8 +: 8] : cur[b*8 +: 8];
    return res;
  endfunction

  logic              timer_en, div_en;
  logic [3:0]        div_val;
  logic [7:0]        pre_cnt, div_mask;
  logic [CNT_W-1:0]  cnt, cnt_inc, cnt_nxt;
  logic [NUM_CH-1:0] tier, tisr, tcmr, match, w1c;
  logic              halt_req, halt_ack;
  logic [CNT_W-1:0]  tcmp [NUM_CH];

  reg_e              sel;
  logic [2:0]        ch;
  logic [CNT_W-1:0]  cmp_sel, cmp_new;
  logic [63:0]       cnt_ext, cnt_wr, cmp_ext, cmp_wr;
  logic [31:0]       tcr_cur, tcr_wr, rdata;
  logic              acc, bad, wr_ok, tcr_err, tcr_wr_ok, tick, inc;
  logic              unused_bits;

  assign ch = apb.tim_paddr[5:3];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel = REG_NONE;
    if (apb.tim_paddr[ADDR_W-1:5] == '0) begin
      case (apb.tim_paddr[4:2])
        3'd0:    sel = REG_TCR;
        3'd1:    sel = REG_TDR0;
        3'd2:    sel = REG_TDR1;
        3'd3:    sel = REG_TIER;
        3'd4:    sel = REG_TISR;
        3'd5:    sel = REG_TCMR;
        3'd6:    sel = REG_THCSR;
        default: sel = REG_NONE;
      endcase
    end else if (apb.tim_paddr[ADDR_W-1:6] == CH_PAGE && int'(ch) < NUM_CH) begin
      sel = apb.tim_paddr[2] ? REG_CMP_H : REG_CMP_L;
    end
  end

  always_comb begin
    cmp_sel = '0;
    for (int n = 0; n < NUM_CH; n++) if (ch == 3'(n)) cmp_sel = tcmp[n];
  end

  // A TCR write is refused if the divider is out of range or is retuned while counting.
  assign tcr_cur = {20'd0, div_val, 6'd0, div_en, timer_en};
  assign tcr_wr  = lane_merge(tcr_cur, apb.tim_pwdata, apb.tim_pstrb);
  assign tcr_err = (tcr_wr[11:8] > 4'd8) |
                   (timer_en & tcr_wr[0] & ({tcr_wr[11:8], tcr_wr[1]} != {div_val, div_en}));

  assign acc       = apb.tim_psel & apb.tim_penable & ~sys_rst;
  assign bad       = (sel == REG_NONE) | (apb.tim_pwrite & (sel == REG_TCR) & tcr_err);
  assign wr_ok     = acc & apb.tim_pwrite & ~bad;
  assign tcr_wr_ok = wr_ok & (sel == REG_TCR);

  assign apb.tim_pready  = acc;
  assign apb.tim_pslverr = acc & bad;
  assign apb.tim_prdata  = (acc & ~apb.tim_pwrite & ~bad) ? rdata : 32'd0;

  assign cnt_ext = 64'(cnt);
  assign cmp_ext = 64'(cmp_sel);

  always_comb begin
    rdata = 32'd0;
    case (sel)
      REG_TCR:   rdata = tcr_cur;
      REG_TDR0:  rdata = cnt_ext[31:0];
      REG_TDR1:  rdata = cnt_ext[63:32];
      REG_TIER:  rdata = 32'(tier);
      REG_TISR:  rdata = 32'(tisr);
      REG_TCMR:  rdata = 32'(tcmr);
      REG_THCSR: rdata = {30'd0, halt_ack, halt_req};
      REG_CMP_L: rdata = cmp_ext[31:0];
      REG_CMP_H: rdata = cmp_ext[63:32];
      default:   rdata = 32'd0;
    endcase
  end

  assign div_mask = 8'((9'd1 << div_val) - 9'd1);
  assign tick     = ~div_en | (pre_cnt == div_mask);
  assign inc      = tick & timer_en & ~halt_ack;

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) match[n] = (cnt == tcmp[n]);
  end

  // Software byte lanes override the freshly incremented count; untouched lanes keep it.
  always_comb begin
    cnt_inc = cnt;
    if (inc) cnt_inc = (|(match & tcmr)) ? '0 : cnt + CNT_W'(1);
    cnt_wr = 64'(cnt_inc);
    if (wr_ok && sel == REG_TDR0) cnt_wr[31:0]  = lane_merge(cnt_wr[31:0],  apb.tim_pwdata, apb.tim_pstrb);
    if (wr_ok && sel == REG_TDR1) cnt_wr[63:32] = lane_merge(cnt_wr[63:32], apb.tim_pwdata, apb.tim_pstrb);
    cnt_nxt = cnt_wr[CNT_W-1:0];
  end

  always_comb begin
    cmp_wr = cmp_ext;
    if (sel == REG_CMP_H) cmp_wr[63:32] = lane_merge(cmp_ext[63:32], apb.tim_pwdata, apb.tim_pstrb);
    else                  cmp_wr[31:0]  = lane_merge(cmp_ext[31:0],  apb.tim_pwdata, apb.tim_pstrb);
    cmp_new = cmp_wr[CNT_W-1:0];
  end

  assign w1c = (wr_ok && sel == REG_TISR && apb.tim_pstrb[0]) ? apb.tim_pwdata[NUM_CH-1:0] : '0;

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= '0;
      pre_cnt  <= '0;
      cnt      <= '0;
      tier     <= '0;
      tisr     <= '0;
      tcmr     <= '0;
      halt_req <= 1'b0;
      halt_ack <= 1'b0;
      tim_int  <= 1'b0;
      // NOTE: the compare bank is a handful of flops, not a RAM, so it is reset like any register.
      for (int n = 0; n < NUM_CH; n++) tcmp[n] <= '1;
    end else begin
      cnt      <= cnt_nxt;
      tisr     <= (tisr & ~w1c) | match;
      tim_int  <= |(tisr & tier);
      halt_ack <= halt_req & dbg_mode;

      if (tcr_wr_ok || !timer_en) pre_cnt <= '0;
      else if (!halt_ack)         pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;

      if (tcr_wr_ok) begin
        timer_en <= tcr_wr[0];
        div_en   <= tcr_wr[1];
        div_val  <= tcr_wr[11:8];
      end
      if (wr_ok && apb.tim_pstrb[0]) begin
        if (sel == REG_TIER)  tier     <= apb.tim_pwdata[NUM_CH-1:0];
        if (sel == REG_TCMR)  tcmr     <= apb.tim_pwdata[NUM_CH-1:0];
        if (sel == REG_THCSR) halt_req <= apb.tim_pwdata[0];
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_ok && (sel == REG_CMP_L || sel == REG_CMP_H) && ch == 3'(n)) tcmp[n] <= cmp_new;
      end
    end
  end

  assign unused_bits = ^{apb.tim_paddr[1:0], tcr_wr[31:12], tcr_wr[7:2]};

endmodule

// File: tb/tb_apb_timer_mch.sv
// Randomised scoreboard bench for apb_timer_mch against a cycle-level behavioural model.
// Stimulus pushes expected responses; a monitor pops them whenever pready is seen.
module tb_apb_timer_mch;
  localparam int CNT_W  = 64;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 12;

  localparam int ID_TCR = 0, ID_TDR0 = 1, ID_TDR1 = 2, ID_TIER = 3, ID_TISR = 4,
                 ID_TCMR = 5, ID_THCSR = 6;
  localparam logic [11:0] A_TCR = 12'h000, A_TDR0 = 12'h004, A_TDR1 = 12'h008,
                          A_TIER = 12'h00C, A_TISR = 12'h010, A_TCMR = 12'h014,
                          A_THCSR = 12'h018, A_CMP0L = 12'h100, A_CMP0H = 12'h104,
                          A_CMP1L = 12'h108, A_CMP1H = 12'h10C;

  logic sys_clk  = 1'b0;
  logic sys_rst  = 1'b1;
  logic dbg_mode = 1'b0;
  logic tim_int;

  apb_timer_mch_if #(.ADDR_W(ADDR_W)) apb ();

  apb_timer_mch #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .apb     (apb.slave),
    .dbg_mode(dbg_mode),
    .tim_int (tim_int)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        is_rd;
    logic [11:0] addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic              m_en, m_div_en, m_hreq, m_hack;
  logic              m_int = 1'b0;
  logic [3:0]        m_div_val;
  int                m_pre;
  logic [63:0]       m_cnt;
  logic [NUM_CH-1:0] m_tier, m_tisr, m_tcmr;
  logic [63:0]       m_cmp [NUM_CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] cur, input logic [31:0] wd,
                                         input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = strb[b] ? wd[b*8 +: 8] : cur[b*8 +: 8];
    return r;
  endfunction

  // -1 unmapped, 0..6 control registers, 16+2n / 17+2n compare low/high of channel n
  function automatic int reg_id(input logic [11:0] a);
    int ai;
    ai = int'(a);
    if (ai < 'h1C) return ai / 4;
    if (ai >= 'h100 && ai < 'h100 + 8 * NUM_CH) return 16 + (ai - 'h100) / 4;
    return -1;
  endfunction

  function automatic logic [31:0] tcr_val();
    return {20'd0, m_div_val, 6'd0, m_div_en, m_en};
  endfunction

  function automatic logic tcr_bad(input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] nv;
    nv = bmerge(tcr_val(), wd, strb);
    return (nv[11:8] > 4'd8) || (m_en && nv[0] && (nv[1] != m_div_en || nv[11:8] != m_div_val));
  endfunction

  function automatic logic [31:0] mread(input int id);
    int k;
    case (id)
      ID_TCR:   return tcr_val();
      ID_TDR0:  return m_cnt[31:0];
      ID_TDR1:  return m_cnt[63:32];
      ID_TIER:  return 32'(m_tier);
      ID_TISR:  return 32'(m_tisr);
      ID_TCMR:  return 32'(m_tcmr);
      ID_THCSR: return {30'd0, m_hack, m_hreq};
      default: begin
        k = id - 16;
        return (k % 2 == 1) ? m_cmp[k/2][63:32] : m_cmp[k/2][31:0];
      end
    endcase
  endfunction

  // One clock edge of the timer described by its rules, all terms from pre-edge state.
  task automatic model_step();
    int id, period, npre, k;
    logic acc, we, tick, halted;
    logic [NUM_CH-1:0] match, w1c;
    logic [63:0] nc;
    logic [31:0] wd, nv;
    logic [3:0] st;
    if (sys_rst) begin
      m_en = 0; m_div_en = 0; m_div_val = 0; m_pre = 0; m_cnt = 0;
      m_tier = 0; m_tisr = 0; m_tcmr = 0; m_hreq = 0; m_hack = 0; m_int = 0;
      for (int n = 0; n < NUM_CH; n++) m_cmp[n] = '1;
      return;
    end
    acc    = apb.tim_psel && apb.tim_penable;
    wd     = apb.tim_pwdata;
    st     = apb.tim_pstrb;
    id     = reg_id(apb.tim_paddr);
    we     = acc && apb.tim_pwrite && id >= 0 && !(id == ID_TCR && tcr_bad(wd, st));
    halted = m_hack;
    period = m_div_en ? (1 << m_div_val) : 1;
    tick   = (m_pre == period - 1);
    for (int n = 0; n < NUM_CH; n++) match[n] = (m_cnt == m_cmp[n]);

    nc = m_cnt;
    if (m_en && !halted && tick) nc = ((match & m_tcmr) != 0) ? 64'd0 : m_cnt + 64'd1;
    if (we && id == ID_TDR0) nc[31:0]  = bmerge(nc[31:0], wd, st);
    if (we && id == ID_TDR1) nc[63:32] = bmerge(nc[63:32], wd, st);

    if ((we && id == ID_TCR) || !m_en) npre = 0;
    else if (halted)                   npre = m_pre;
    else                               npre = tick ? 0 : m_pre + 1;

    w1c    = (we && id == ID_TISR && st[0]) ? wd[NUM_CH-1:0] : '0;
    m_int  = |(m_tisr & m_tier);
    m_hack = m_hreq & dbg_mode;
    m_tisr = (m_tisr & ~w1c) | match;
    if (we) begin
      case (id)
        ID_TCR: begin
          nv = bmerge(tcr_val(), wd, st);
          m_en = nv[0]; m_div_en = nv[1]; m_div_val = nv[11:8];
        end
        ID_TIER:  if (st[0]) m_tier = wd[NUM_CH-1:0];
        ID_TCMR:  if (st[0]) m_tcmr = wd[NUM_CH-1:0];
        ID_THCSR: if (st[0]) m_hreq = wd[0];
        default: if (id >= 16) begin
          k = id - 16;
          if (k % 2 == 1) m_cmp[k/2][63:32] = bmerge(m_cmp[k/2][63:32], wd, st);
          else            m_cmp[k/2][31:0]  = bmerge(m_cmp[k/2][31:0], wd, st);
        end
      endcase
    end
    m_cnt = nc;
    m_pre = npre;
  endtask

  always @(posedge sys_clk) model_step();

  // Monitor: interrupt every cycle, bus responses whenever pready shows up.
  always @(negedge sys_clk) begin
    exp_t e;
    check("tim_int", 64'(tim_int), 64'(m_int));
    if (apb.tim_pready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pready: actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        check($sformatf("pslverr@%h", e.addr), 64'(apb.tim_pslverr), 64'(e.err));
        if (e.is_rd) check($sformatf("prdata@%h", e.addr), 64'(apb.tim_prdata), 64'(e.data));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb);
    exp_t e;
    int id;
    apb.tim_psel    = 1'b1;
    apb.tim_penable = 1'b0;
    apb.tim_pwrite  = wr;
    apb.tim_paddr   = addr;
    apb.tim_pwdata  = wd;
    apb.tim_pstrb   = strb;
    cyc(1);
    apb.tim_penable = 1'b1;
    id      = reg_id(addr);
    e.is_rd = !wr;
    e.addr  = addr;
    e.err   = (id < 0) || (wr && id == ID_TCR && tcr_bad(wd, strb));
    e.data  = (e.err || wr) ? 32'd0 : mread(id);
    sb.push_back(e);
    cyc(1);
    apb.tim_psel    = 1'b0;
    apb.tim_penable = 1'b0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] d);
    xfer(1'b1, addr, d, 4'hF);
  endtask

  task automatic rd(input logic [11:0] addr);
    xfer(1'b0, addr, $urandom, 4'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    int pick;
    apb.tim_psel = 0; apb.tim_penable = 0; apb.tim_pwrite = 0;
    apb.tim_paddr = '0; apb.tim_pwdata = '0; apb.tim_pstrb = '0;
    cyc(2);
    sys_rst = 1'b0;

    // Reset asserted mid-count and mid-transfer
    wr(A_TCR, 32'h1);
    cyc(10);
    apb.tim_psel = 1; apb.tim_pwrite = 1; apb.tim_paddr = A_TIER;
    apb.tim_pwdata = 32'h1; apb.tim_pstrb = 4'hF;
    cyc(1);
    apb.tim_penable = 1'b1;
    sys_rst = 1'b1;
    cyc(1);
    @(negedge sys_clk);
    check("rst_pready", 64'(apb.tim_pready), 64'd0);
    check("rst_pslverr", 64'(apb.tim_pslverr), 64'd0);
    check("rst_prdata", 64'(apb.tim_prdata), 64'd0);
    check("rst_tim_int", 64'(tim_int), 64'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    apb.tim_psel = 0; apb.tim_penable = 0;
    rd(A_TDR0); rd(A_TDR1); rd(A_CMP0L); rd(A_CMP0H); rd(A_TIER); rd(A_TCR);

    // Match on channel 0, interrupt, W1C
    wr(A_CMP0L, 32'd5); wr(A_CMP0H, 32'd0); wr(A_TIER, 32'h1); wr(A_TCR, 32'h1);
    repeat (6) begin rd(A_TDR0); rd(A_TISR); end
    wr(A_TISR, 32'h1); rd(A_TISR); cyc(2); rd(A_TISR);

    // Prescaler by 4, illegal divider, retune while running
    wr(A_TCR, 32'h0); wr(A_TDR0, 32'h0); wr(A_TDR1, 32'h0); wr(A_TCR, 32'h203);
    repeat (10) rd(A_TDR0);
    wr(A_TCR, 32'h903); rd(A_TCR);
    wr(A_TCR, 32'h303); rd(A_TCR);
    xfer(1'b1, A_TCR, 32'h0000_0900, 4'b0010); rd(A_TCR);

    // Periodic mode on channel 1
    wr(A_TCR, 32'h0); wr(A_TDR0, 32'h0); wr(A_TDR1, 32'h0);
    wr(A_CMP1L, 32'd3); wr(A_CMP1H, 32'd0); wr(A_TCMR, 32'h2); wr(A_TCR, 32'h1);
    repeat (10) rd(A_TDR0);
    rd(A_TISR); wr(A_TISR, 32'hF); rd(A_TISR);

    // Debug halt and resume
    dbg_mode = 1'b1;
    wr(A_THCSR, 32'h1); rd(A_THCSR);
    repeat (4) rd(A_TDR0);
    dbg_mode = 1'b0;
    rd(A_THCSR);
    repeat (4) rd(A_TDR0);
    wr(A_THCSR, 32'h0); wr(A_TCMR, 32'h0);

    // 64-bit wrap, lane-masked write during count, unmapped addresses
    wr(A_TCR, 32'h0); wr(A_TDR0, 32'hFFFF_FFFE); wr(A_TDR1, 32'hFFFF_FFFF); rd(A_TDR1);
    wr(A_TCR, 32'h1);
    rd(A_TDR0); rd(A_TDR1); rd(A_TDR0);
    xfer(1'b1, A_TDR0, 32'hA5A5_A5A5, 4'h1); rd(A_TDR0);
    rd(12'h0F0); xfer(1'b1, 12'h0F0, 32'hFFFF_FFFF, 4'hF);
    rd(12'h120); rd(12'h01C); rd(A_TIER);

    // Randomised register traffic
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2, 3, 4, 5, 6: a = 12'(pick * 4);
        7:       a = 12'('h100 + 4 * $urandom_range(0, 2 * NUM_CH - 1));
        8:       a = 12'('h100 + $urandom_range(0, 63));
        default: a = 12'($urandom);
      endcase
      d = $urandom;
      if (pick == ID_TCR) d = ($urandom_range(0, 9) << 8) | $urandom_range(0, 3);
      else if ((pick == ID_TDR0 || pick == 7) && $urandom_range(0, 1) == 1) d = $urandom_range(0, 40);
      else if (pick == ID_TDR1 && $urandom_range(0, 1) == 1) d = 32'd0;
      if ($urandom_range(0, 15) == 0) dbg_mode = ~dbg_mode;
      if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 20));
      xfer(1'($urandom_range(0, 1)), a, d, 4'($urandom));
    end

    cyc(3);
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
